// File: rtl/buzzer_sustain_ctrl.sv
// Multi-channel buzzer sustain controller.
// Each key channel keeps sounding for a programmable number of cycles after
// release, or stops at release when hold mode is on. A newest-key priority
// picks which channel drives the single buzzer, and a one-cycle done pulse
// marks the moment the last channel falls silent.
// Optional build macro: BUZZER_DECAY_EN (50 % duty decay in the second half
// of the selected channel's tail).
module buzzer_sustain_ctrl #(
  parameter int CHANNELS        = 8,
  parameter int CNT_W           = 21,
  parameter int SUSTAIN_DEFAULT = 200000,
  localparam int NOTE_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [CHANNELS-1:0] iKey,
  input  logic [CNT_W-1:0]    iSustainLen,
  input  logic                iSustainLoad,
  input  logic                iHoldMode,
  output logic [CHANNELS-1:0] oChanActive,
  output logic [NOTE_W-1:0]   oNote,
  output logic                oRing,
  output logic                oDone
);

`ifdef BUZZER_DECAY_EN
  // Counter bit that toggles the buzzer during the decay half of a tail.
  localparam int DECAY_BIT = (CNT_W > 3) ? 3 : CNT_W - 1;
`endif

  // Key history and rising-edge detect.
  logic [CHANNELS-1:0] key_q, key_d;
  logic [CHANNELS-1:0] key_rise;

  // Per-channel sustain state.
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] active_q, active_d;

  // Programmable sustain length.
  logic [CNT_W-1:0]    len_q, len_d;

  // Most recently pressed channel.
  logic [NOTE_W-1:0]   newest_q, newest_d;

  // Output stage, all one cycle behind the channel state.
  logic [NOTE_W-1:0]   note_q, note_d;
  logic                ring_q, ring_d;
  logic                any_q, any_d;
  logic                done_q, done_d;

  // Channel selection helpers.
  logic [NOTE_W-1:0]   lowest_active;
  logic [NOTE_W-1:0]   sel_chan;

  assign key_d    = iKey;
  assign key_rise = iKey & ~key_q;

  // Length register: a zero length would make every tail degenerate, so it is ignored.
  always_comb begin
    len_d = len_q;
    if (iSustainLoad && (iSustainLen != '0)) begin
      len_d = iSustainLen;
    end
  end

  // Per-channel counter: held key pins the counter at 1, release runs the tail.
  // The >= compare lets a shortened length end longer tails immediately, and
  // the counter stops at length so it can never wrap.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      cnt_d[k]    = cnt_q[k];
      active_d[k] = active_q[k];
      if (iKey[k]) begin
        cnt_d[k]    = CNT_W'(1);
        active_d[k] = 1'b1;
      end else if (cnt_q[k] != '0) begin
        if (iHoldMode || (cnt_q[k] >= len_q)) begin
          cnt_d[k]    = '0;
          active_d[k] = 1'b0;
        end else begin
          cnt_d[k]    = cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // Newest channel: lowest index wins when several keys rise together.
  always_comb begin
    newest_d = newest_q;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (key_rise[k]) begin
        newest_d = NOTE_W'(k);
      end
    end
  end

  // Lowest-index active channel, used once the newest channel has gone quiet.
  always_comb begin
    lowest_active = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (active_q[k]) begin
        lowest_active = NOTE_W'(k);
      end
    end
  end

  // Buzzer source selection, ring enable and end-of-sound detection.
  always_comb begin
    if (active_q[newest_q]) begin
      sel_chan = newest_q;
    end else if (|active_q) begin
      sel_chan = lowest_active;
    end else begin
      sel_chan = '0;
    end
    note_d = sel_chan;
    any_d  = |active_q;
    ring_d = any_d;
`ifdef BUZZER_DECAY_EN
    // Second half of a released tail chops the buzzer at half duty.
    if (any_d && active_q[sel_chan] && !key_q[sel_chan] &&
        (cnt_q[sel_chan] >= (len_q >> 1))) begin
      ring_d = cnt_q[sel_chan][DECAY_BIT];
    end
`endif
    done_d = any_q & ~any_d;
  end

  // State register; reset aborts every tail without a done pulse.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      key_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= '0;
      end
      active_q <= '0;
      len_q    <= CNT_W'(SUSTAIN_DEFAULT);
      newest_q <= '0;
      note_q   <= '0;
      ring_q   <= 1'b0;
      any_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      key_q    <= key_d;
      for (int k = 0; k < CHANNELS; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      active_q <= active_d;
      len_q    <= len_d;
      newest_q <= newest_d;
      note_q   <= note_d;
      ring_q   <= ring_d;
      any_q    <= any_d;
      done_q   <= done_d;
    end
  end

  assign oChanActive = active_q;
  assign oNote       = note_q;
  assign oRing       = ring_q;
  assign oDone       = done_q;

endmodule

// File: tb/tb_buzzer_sustain_ctrl.sv
// Directed testbench for buzzer_sustain_ctrl (CHANNELS=4, CNT_W=8, SUSTAIN_DEFAULT=10).
module tb_buzzer_sustain_ctrl;

  logic       iClk;
  logic       iReset_n;
  logic [3:0] iKey;
  logic [7:0] iSustainLen;
  logic       iSustainLoad;
  logic       iHoldMode;
  logic [3:0] oChanActive;
  logic [1:0] oNote;
  logic       oRing;
  logic       oDone;

  int total;
  int bad;

  buzzer_sustain_ctrl #(
    .CHANNELS       (4),
    .CNT_W          (8),
    .SUSTAIN_DEFAULT(10)
  ) dut (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .iKey        (iKey),
    .iSustainLen (iSustainLen),
    .iSustainLoad(iSustainLoad),
    .iHoldMode   (iHoldMode),
    .oChanActive (oChanActive),
    .oNote       (oNote),
    .oRing       (oRing),
    .oDone       (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // One clock edge; outputs are stable 1 time unit after it.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    iReset_n     = 1'b0;
    iKey         = 4'b0000;
    iSustainLen  = 8'd0;
    iSustainLoad = 1'b0;
    iHoldMode    = 1'b0;

    // Reset state
    ticks(2);
    chk("rst_act",  32'(oChanActive), 32'h0);
    chk("rst_note", 32'(oNote),       32'h0);
    chk("rst_ring", 32'(oRing),       32'h0);
    chk("rst_done", 32'(oDone),       32'h0);
    iReset_n = 1'b1;
    tick();

    // Single channel press, 10-edge tail, done pulse
    iKey = 4'b0100;
    tick();
    chk("t1_act_press", 32'(oChanActive), 32'h4);
    chk("t1_ring_lat",  32'(oRing),       32'h0);
    tick();
    chk("t1_ring_on",   32'(oRing),       32'h1);
    chk("t1_note",      32'(oNote),       32'h2);
    tick();
    iKey = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t1_tail_%0d", i), 32'(oChanActive), (i < 10) ? 32'h4 : 32'h0);
    end
    chk("t1_ring_hold", 32'(oRing), 32'h1);
    chk("t1_done_pre",  32'(oDone), 32'h0);
    tick();
    chk("t1_ring_off",  32'(oRing), 32'h0);
    chk("t1_done",      32'(oDone), 32'h1);
    tick();
    chk("t1_done_one",  32'(oDone), 32'h0);

    // Newest-key priority, tail of the newer note keeps priority
    iKey = 4'b0010;
    tick();
    chk("t2_act1", 32'(oChanActive), 32'h2);
    tick();
    chk("t2_note1", 32'(oNote), 32'h1);
    ticks(3);
    iKey = 4'b1010;
    tick();
    chk("t2_act13", 32'(oChanActive), 32'hA);
    tick();
    chk("t2_note3", 32'(oNote), 32'h3);
    iKey = 4'b0010;
    ticks(9);
    chk("t2_tail_note", 32'(oNote),       32'h3);
    chk("t2_tail_act",  32'(oChanActive), 32'hA);
    tick();
    chk("t2_end_act",   32'(oChanActive), 32'h2);
    chk("t2_end_note",  32'(oNote),       32'h3);
    tick();
    chk("t2_back_note", 32'(oNote),       32'h1);
    chk("t2_ring",      32'(oRing),       32'h1);
    iKey = 4'b0000;
    ticks(12);
    chk("t2_idle_act",  32'(oChanActive), 32'h0);
    chk("t2_idle_ring", 32'(oRing),       32'h0);

    // Simultaneous rise: lowest index is newest
    iKey = 4'b0101;
    tick();
    chk("t3_act",  32'(oChanActive), 32'h5);
    tick();
    chk("t3_note", 32'(oNote),       32'h0);
    iKey = 4'b0000;
    ticks(12);

    // Shorten length mid-tail; zero load ignored
    iKey = 4'b0001;
    tick();
    iKey = 4'b0000;
    ticks(6);
    iSustainLen  = 8'd4;
    iSustainLoad = 1'b1;
    tick();
    iSustainLoad = 1'b0;
    chk("t4_load_act", 32'(oChanActive), 32'h1);
    tick();
    chk("t4_cut_act",  32'(oChanActive), 32'h0);
    iSustainLen  = 8'd0;
    iSustainLoad = 1'b1;
    tick();
    iSustainLoad = 1'b0;
    iKey = 4'b0001;
    tick();
    iKey = 4'b0000;
    ticks(3);
    chk("t4_len4_act3", 32'(oChanActive), 32'h1);
    tick();
    chk("t4_len4_end",  32'(oChanActive), 32'h0);
    ticks(3);

    // Hold mode stops at release; retrigger restarts tail without done
    iHoldMode = 1'b1;
    iKey = 4'b0010;
    tick();
    iKey = 4'b0000;
    tick();
    chk("t5_hold_act",  32'(oChanActive), 32'h0);
    chk("t5_hold_ring", 32'(oRing),       32'h1);
    tick();
    chk("t5_hold_done", 32'(oDone),       32'h1);
    iHoldMode = 1'b0;
    iKey = 4'b0010;
    tick();
    iKey = 4'b0000;
    ticks(2);
    iKey = 4'b0010;
    tick();
    chk("t5_retrig_act",  32'(oChanActive), 32'h2);
    chk("t5_retrig_done", 32'(oDone),       32'h0);
    iKey = 4'b0000;
    ticks(3);
    chk("t5_restart_act",  32'(oChanActive), 32'h2);
    chk("t5_restart_done", 32'(oDone),       32'h0);
    tick();
    chk("t5_restart_end",  32'(oChanActive), 32'h0);
    ticks(3);

    // Reset mid-tail: outputs clear, no done, length back to 10
    iKey = 4'b0100;
    tick();
    iKey = 4'b0000;
    ticks(2);
    iReset_n = 1'b0;
    tick();
    chk("t6_act",  32'(oChanActive), 32'h0);
    chk("t6_note", 32'(oNote),       32'h0);
    chk("t6_ring", 32'(oRing),       32'h0);
    chk("t6_done", 32'(oDone),       32'h0);
    iReset_n = 1'b1;
    tick();
    chk("t6_post_done", 32'(oDone), 32'h0);
    chk("t6_post_ring", 32'(oRing), 32'h0);
    iKey = 4'b0001;
    tick();
    iKey = 4'b0000;
    ticks(9);
    chk("t6_len10_act9", 32'(oChanActive), 32'h1);
    tick();
    chk("t6_len10_end",  32'(oChanActive), 32'h0);
    ticks(3);

    // Key held through reset release rises on the first active edge
    iReset_n = 1'b0;
    iKey = 4'b1000;
    tick();
    chk("t7_rst_act", 32'(oChanActive), 32'h0);
    iReset_n = 1'b1;
    tick();
    chk("t7_act",  32'(oChanActive), 32'h8);
    tick();
    chk("t7_note", 32'(oNote),       32'h3);
    chk("t7_ring", 32'(oRing),       32'h1);
    iKey = 4'b0000;
    ticks(12);
    chk("t7_idle", 32'(oChanActive), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
